// File: rtl/ct_mmu_jtlb_pkg.sv
// -----------------------------------------------------------------------------
// ct_mmu_jtlb_pkg
// Shared definitions for the jTLB SRAM controller slice.
//   JTLB_ADDR_WIDTH  - index width of the jTLB SRAM (depth = 1 << width)
//   JTLB_DATA_WIDTH  - entry width, also the per-bit write-enable width
//   JTLB_SWEEP_LAST  - last index visited by the invalidate-all sweep
//   jtlb_fsm_e       - controller state encoding (IDLE / SWEEP)
// -----------------------------------------------------------------------------
package ct_mmu_jtlb_pkg;

    localparam int JTLB_ADDR_WIDTH = 8;
    localparam int JTLB_DATA_WIDTH = 196;
    localparam int JTLB_SWEEP_LAST = (1 << JTLB_ADDR_WIDTH) - 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } jtlb_fsm_e;

endpackage

// File: rtl/ct_mmu_jtlb_inv_walker.sv
// -----------------------------------------------------------------------------
// ct_mmu_jtlb_inv_walker
// Invalidate-all sweep sequencer. On a start request seen in IDLE it walks
// every SRAM index once (one per cycle), raising busy for the whole walk and
// a one-cycle done pulse in the cycle that addresses the last index.
// Ports:
//   i_clk    - clock
//   i_rst_n  - asynchronous reset, active low
//   i_start  - start request (level, only looked at in IDLE)
//   o_busy   - sweep in progress; o_cnt is the index being cleared
//   o_done   - high in the cycle that clears the last index
//   o_cnt    - current sweep index
// -----------------------------------------------------------------------------
module ct_mmu_jtlb_inv_walker
    import ct_mmu_jtlb_pkg::*;
#(
    parameter int ADDR_WIDTH = JTLB_ADDR_WIDTH,
    parameter int LAST_IDX   = JTLB_SWEEP_LAST
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH-1:0] o_cnt
);

    localparam logic [ADDR_WIDTH-1:0] W_LAST = LAST_IDX[ADDR_WIDTH-1:0];

    jtlb_fsm_e             r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_busy;
    logic                  r_done;

    // busy/done are registered so they line up with the index held in r_cnt;
    // done is set one cycle early so it is high while r_cnt == W_LAST.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_state <= ST_SWEEP;
                        r_busy  <= 1'b1;
                        r_done  <= (W_LAST == '0);
                    end
                end
                ST_SWEEP: begin
                    if (r_cnt == W_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt  <= r_cnt + 1'b1;
                        r_done <= (r_cnt == (W_LAST - 1'b1));
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/ct_mmu_jtlb_sram_ctrl.sv
// -----------------------------------------------------------------------------
// ct_mmu_jtlb_sram_ctrl
// Sole driver of the jTLB single-port SRAM macro (active-low CEN/GWEN/bit-WEN,
// one-cycle read). Arbitrates invalidate-all sweep > refill/update write >
// lookup read onto the port, one access per cycle, and returns read data to
// the compare stage with a fixed latency. The macro is deselected when idle.
// Ports:
//   forever_cpuclk, cpurst_b          - clock, async reset (active low)
//   rd_req_vld/idx, rd_req_rdy        - lookup read request / accept
//   rd_resp_vld, rd_resp_data         - read response
//   wr_req_vld/idx/data/bmask, wr_req_rdy - write request (bmask 1 = write bit)
//   inv_all_req, inv_all_busy, inv_all_done - invalidate-all sweep control
//   sram_cen/gwen/wen/a/d, sram_q     - SRAM macro interface
// Configuration:
//   CT_JTLB_SRAM_OUTREG_EN - when defined, sram_q is captured in a flop and
//   the response appears 2 cycles after accept; otherwise 1 cycle, with
//   rd_resp_data wired straight to sram_q (meaningful only while valid).
// -----------------------------------------------------------------------------
module ct_mmu_jtlb_sram_ctrl
    import ct_mmu_jtlb_pkg::*;
#(
    parameter int ADDR_WIDTH = JTLB_ADDR_WIDTH,
    parameter int DATA_WIDTH = JTLB_DATA_WIDTH
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  rd_req_vld,
    input  logic [ADDR_WIDTH-1:0] rd_req_idx,
    output logic                  rd_req_rdy,
    output logic                  rd_resp_vld,
    output logic [DATA_WIDTH-1:0] rd_resp_data,
    input  logic                  wr_req_vld,
    input  logic [ADDR_WIDTH-1:0] wr_req_idx,
    input  logic [DATA_WIDTH-1:0] wr_req_data,
    input  logic [DATA_WIDTH-1:0] wr_req_bmask,
    output logic                  wr_req_rdy,
    input  logic                  inv_all_req,
    output logic                  inv_all_busy,
    output logic                  inv_all_done,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam int LAST_IDX = (1 << ADDR_WIDTH) - 1;

    logic                  w_busy;
    logic                  w_done;
    logic [ADDR_WIDTH-1:0] w_cnt;
    logic                  w_idle_ok;
    logic                  w_wr_gnt;
    logic                  w_rd_gnt;
    logic                  r_rd_vld_p0;

    ct_mmu_jtlb_inv_walker #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LAST_IDX   (LAST_IDX)
    ) u_inv_walker (
        .i_clk   (forever_cpuclk),
        .i_rst_n (cpurst_b),
        .i_start (inv_all_req),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_cnt   (w_cnt)
    );

    // A pending sweep request takes the cycle with no access at all, so the
    // sweep starts cleanly on the next edge. Grants are also held off while
    // reset is asserted so the macro stays deselected asynchronously.
    assign w_idle_ok = cpurst_b & ~w_busy & ~inv_all_req;
    assign w_wr_gnt  = w_idle_ok & wr_req_vld;
    assign w_rd_gnt  = w_idle_ok & ~wr_req_vld & rd_req_vld;

    assign wr_req_rdy   = w_wr_gnt;
    assign rd_req_rdy   = w_rd_gnt;
    assign inv_all_busy = w_busy;
    assign inv_all_done = w_done;

    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = '0;
        sram_d    = '0;
        if (w_busy) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = w_cnt;
        end else if (w_wr_gnt) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = ~wr_req_bmask;
            sram_a    = wr_req_idx;
            sram_d    = wr_req_data;
        end else if (w_rd_gnt) begin
            sram_cen  = 1'b0;
            sram_a    = rd_req_idx;
        end
    end

    // p0: macro read cycle done, sram_q valid
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_rd_vld_p0 <= 1'b0;
        end else begin
            r_rd_vld_p0 <= w_rd_gnt;
        end
    end

`ifdef CT_JTLB_SRAM_OUTREG_EN
    logic                  r_rd_vld_p1;
    logic [DATA_WIDTH-1:0] r_rd_data_p1;

    // p1: read data captured; flop only loads on a valid response
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_rd_vld_p1  <= 1'b0;
            r_rd_data_p1 <= '0;
        end else begin
            r_rd_vld_p1 <= r_rd_vld_p0;
            if (r_rd_vld_p0) begin
                r_rd_data_p1 <= sram_q;
            end
        end
    end

    assign rd_resp_vld  = r_rd_vld_p1;
    assign rd_resp_data = r_rd_data_p1;
`else
    assign rd_resp_vld  = r_rd_vld_p0;
    assign rd_resp_data = sram_q;
`endif

endmodule

// File: tb/tb_ct_mmu_jtlb_sram_ctrl.sv
module tb_ct_mmu_jtlb_sram_ctrl;

    localparam int AW = 8;
    localparam int DW = 196;
`ifdef CT_JTLB_SRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam logic [DW-1:0] PAT_A5  = {4'hA, {24{8'hA5}}};
    localparam logic [DW-1:0] PAT_3C  = {4'h3, {24{8'hC3}}};
    localparam logic [DW-1:0] PAT_PRT = {4'h3, {23{8'hC3}}, 8'hA5};
    localparam logic [DW-1:0] D1      = {4'h1, {24{8'h11}}};
    localparam logic [DW-1:0] D2      = {4'h2, {24{8'h22}}};
    localparam logic [DW-1:0] D4      = {4'h4, {24{8'h4B}}};
    localparam logic [DW-1:0] ALL1    = {DW{1'b1}};
    localparam logic [DW-1:0] LO8     = {{(DW-8){1'b0}}, 8'hFF};

    logic          clk;
    logic          cpurst_b;
    logic          rd_req_vld;
    logic [AW-1:0] rd_req_idx;
    logic          rd_req_rdy;
    logic          rd_resp_vld;
    logic [DW-1:0] rd_resp_data;
    logic          wr_req_vld;
    logic [AW-1:0] wr_req_idx;
    logic [DW-1:0] wr_req_data;
    logic [DW-1:0] wr_req_bmask;
    logic          wr_req_rdy;
    logic          inv_all_req;
    logic          inv_all_busy;
    logic          inv_all_done;
    logic          sram_cen;
    logic          sram_gwen;
    logic [DW-1:0] sram_wen;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q;

    ct_mmu_jtlb_sram_ctrl dut (
        .forever_cpuclk (clk),
        .cpurst_b       (cpurst_b),
        .rd_req_vld     (rd_req_vld),
        .rd_req_idx     (rd_req_idx),
        .rd_req_rdy     (rd_req_rdy),
        .rd_resp_vld    (rd_resp_vld),
        .rd_resp_data   (rd_resp_data),
        .wr_req_vld     (wr_req_vld),
        .wr_req_idx     (wr_req_idx),
        .wr_req_data    (wr_req_data),
        .wr_req_bmask   (wr_req_bmask),
        .wr_req_rdy     (wr_req_rdy),
        .inv_all_req    (inv_all_req),
        .inv_all_busy   (inv_all_busy),
        .inv_all_done   (inv_all_done),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_wen       (sram_wen),
        .sram_a         (sram_a),
        .sram_d         (sram_d),
        .sram_q         (sram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 256x196 macro: active-low enables, 1-cycle registered read.
    logic [DW-1:0] mem [1<<AW];
    initial begin
        for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
        sram_q = '0;
    end
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else            sram_q <= mem[sram_a];
        end
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [DW-1:0] data;
        int unsigned   due;
        string         nm;
    } exp_t;
    exp_t sb[$];

    // Monitor: pops the scoreboard whenever a response is presented.
    always @(negedge clk) begin
        if (cpurst_b) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s: no response by cycle %0d", sb[0].nm, sb[0].due);
                void'(sb.pop_front());
            end
            if (rd_resp_vld) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rd_resp_unexpected: got data %h with nothing outstanding", rd_resp_data);
                end else if (sb[0].due != cyc) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL %s: response at cycle %0d expected at %0d", sb[0].nm, cyc, sb[0].due);
                    void'(sb.pop_front());
                end else begin
                    chk(sb[0].nm, rd_resp_data, sb[0].data);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_resp_vld"}, DW'(rd_resp_vld), '0);
        chk({tag, "_busy"}, DW'(inv_all_busy), '0);
        chk({tag, "_done"}, DW'(inv_all_done), '0);
        chk({tag, "_cen"}, DW'(sram_cen), DW'(1));
        chk({tag, "_gwen"}, DW'(sram_gwen), DW'(1));
        chk({tag, "_wen"}, sram_wen, ALL1);
        chk({tag, "_a"}, DW'(sram_a), '0);
        chk({tag, "_d"}, sram_d, '0);
        chk({tag, "_rdys"}, DW'({rd_req_rdy, wr_req_rdy}), '0);
`ifdef CT_JTLB_SRAM_OUTREG_EN
        chk({tag, "_resp_data"}, rd_resp_data, '0);
`endif
    endtask

    task automatic do_wr(input logic [AW-1:0] idx, input logic [DW-1:0] dat, input logic [DW-1:0] msk);
        int n;
        @(negedge clk);
        wr_req_vld = 1'b1; wr_req_idx = idx; wr_req_data = dat; wr_req_bmask = msk;
        #1;
        n = 0;
        while (wr_req_rdy !== 1'b1 && n < 400) begin
            @(negedge clk); #1; n++;
        end
        chk("wr_accept", DW'(wr_req_rdy), DW'(1));
        chk("wr_port_ctl", DW'({sram_cen, sram_gwen, sram_a}), DW'({1'b0, 1'b0, idx}));
        chk("wr_port_wen", sram_wen, ~msk);
        chk("wr_port_d", sram_d, dat);
        @(posedge clk); #1;
        wr_req_vld = 1'b0;
    endtask

    task automatic do_rd(input logic [AW-1:0] idx, input logic [DW-1:0] exp, input string nm);
        int n;
        @(negedge clk);
        rd_req_vld = 1'b1; rd_req_idx = idx;
        #1;
        n = 0;
        while (rd_req_rdy !== 1'b1 && n < 400) begin
            @(negedge clk); #1; n++;
        end
        chk("rd_accept", DW'(rd_req_rdy), DW'(1));
        chk("rd_port_ctl", DW'({sram_cen, sram_gwen, sram_a}), DW'({1'b0, 1'b1, idx}));
        chk("rd_port_wen", sram_wen, ALL1);
        if (rd_req_rdy === 1'b1) sb.push_back('{exp, cyc + LAT, nm});
        @(posedge clk); #1;
        rd_req_vld = 1'b0;
    endtask

    task automatic run_sweep();
        logic [15:0] act;
        logic [15:0] exp;
        @(negedge clk);
        inv_all_req = 1'b1;
        #1;
        chk("sweep_req_noaccess", DW'({sram_cen, rd_req_rdy, wr_req_rdy}), DW'(3'b100));
        @(posedge clk); #1;
        inv_all_req = 1'b0;
        for (int i = 0; i < (1<<AW); i++) begin
            @(negedge clk); #1;
            act = {inv_all_busy, sram_cen, sram_gwen, inv_all_done, rd_req_rdy, wr_req_rdy,
                   (sram_wen == '0), (sram_d == '0), sram_a};
            exp = {1'b1, 1'b0, 1'b0, (i == (1<<AW) - 1), 1'b0, 1'b0, 1'b1, 1'b1, i[AW-1:0]};
            chk($sformatf("sweep_cyc%0d", i), DW'(act), DW'(exp));
        end
        @(negedge clk); #1;
        chk("sweep_end", DW'({inv_all_busy, inv_all_done}), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        cpurst_b = 1'b0;
        rd_req_vld = 1'b1; rd_req_idx = 8'h3C;
        wr_req_vld = 1'b1; wr_req_idx = 8'h11; wr_req_data = D1; wr_req_bmask = ALL1;
        inv_all_req = 1'b0;
        #3;
        chk_reset_vals("rst_init");
        rd_req_vld = 1'b0; wr_req_vld = 1'b0;
        @(negedge clk);
        cpurst_b = 1'b1;

        // Write then read back on the next cycle
        do_wr(8'h3C, PAT_A5, ALL1);
        do_rd(8'h3C, PAT_A5, "rd_after_wr_3c");

        // Partial write: only the low 8 bits change
        do_wr(8'h05, PAT_3C, ALL1);
        do_rd(8'h05, PAT_3C, "rd_full_05");
        do_wr(8'h05, PAT_A5, LO8);
        do_rd(8'h05, PAT_PRT, "rd_partial_05");

        // Same-cycle write and read: write wins, read goes next cycle
        do_wr(8'h20, D2, ALL1);
        @(negedge clk);
        wr_req_vld = 1'b1; wr_req_idx = 8'h10; wr_req_data = D1; wr_req_bmask = ALL1;
        rd_req_vld = 1'b1; rd_req_idx = 8'h20;
        #1;
        chk("conflict_rdys", DW'({wr_req_rdy, rd_req_rdy}), DW'(2'b10));
        @(posedge clk); #1;
        wr_req_vld = 1'b0;
        @(negedge clk); #1;
        chk("conflict_rd_next", DW'(rd_req_rdy), DW'(1));
        if (rd_req_rdy === 1'b1) sb.push_back('{D2, cyc + LAT, "rd_conflict_20"});
        @(posedge clk); #1;
        rd_req_vld = 1'b0;
        do_rd(8'h10, D1, "rd_10");

        // Back-to-back reads
        do_rd(8'h3C, PAT_A5, "b2b_0");
        do_rd(8'h20, D2, "b2b_1");
        do_rd(8'h05, PAT_PRT, "b2b_2");

        // Asynchronous reset with a read in flight and requests active
        @(negedge clk);
        rd_req_vld = 1'b1; rd_req_idx = 8'h3C;
        @(posedge clk); #2;
        wr_req_vld = 1'b1; wr_req_idx = 8'h77; wr_req_data = D4; wr_req_bmask = ALL1;
        cpurst_b = 1'b0;
        sb.delete();
        #1;
        chk_reset_vals("rst_mid");
        rd_req_vld = 1'b0; wr_req_vld = 1'b0;
        @(negedge clk);
        cpurst_b = 1'b1;
        do_rd(8'h3C, PAT_A5, "rd_after_reset");

        // Invalidate-all with write and read held pending throughout
        wr_req_vld = 1'b1; wr_req_idx = 8'h40; wr_req_data = D4; wr_req_bmask = ALL1;
        rd_req_vld = 1'b1; rd_req_idx = 8'h3C;
        run_sweep();
        do_wr(8'h40, D4, ALL1);
        do_rd(8'h3C, '0, "rd_swept_3c");
        do_rd(8'h05, '0, "rd_swept_05");
        do_rd(8'h40, D4, "rd_post_sweep_40");

        // Reset in the middle of a sweep
        @(negedge clk);
        inv_all_req = 1'b1;
        @(posedge clk); #1;
        inv_all_req = 1'b0;
        n = 0;
        @(negedge clk); #1;
        while (!(inv_all_busy === 1'b1 && sram_a === 8'd100) && n < 300) begin
            @(negedge clk); #1; n++;
        end
        chk("sweep_reach_100", DW'(sram_a), DW'(100));
        cpurst_b = 1'b0;
        #1;
        chk("rst_sweep_busy_done", DW'({inv_all_busy, inv_all_done}), '0);
        chk("rst_sweep_cen", DW'(sram_cen), DW'(1));
        @(negedge clk);
        cpurst_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("post_rst_idle", DW'({inv_all_busy, inv_all_done, sram_cen}), DW'(3'b001));
        end
        run_sweep();
        do_rd(8'h40, '0, "rd_after_resweep");

        repeat (4) @(negedge clk);
        chk("sb_drained", DW'(sb.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
